// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the register-file write path.
// The WB stage, the register file and the writeback arbiter all import these.
package wb_port_arbiter_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of WB-stage, multi-cycle-unit and register-file signals around the arbiter.
// master = pipeline/mc unit/register file side, slave = arbiter.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                wb_we;
  logic [ADDR_W-1:0]   wb_rd;
  logic [DATA_W-1:0]   wb_data;
  logic                mc_valid;
  logic [ADDR_W-1:0]   mc_rd;
  logic [DATA_W-1:0]   mc_data;
  logic                mc_ready;
  logic                stall_wb;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_rd;
  logic [DATA_W-1:0]   rf_data;
  logic [NUM_REGS-1:0] mc_pending;
  logic                waw_err;

  modport master (
    output wb_we, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
    input  mc_ready, stall_wb, rf_we, rf_rd, rf_data, mc_pending, waw_err
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, mc_valid, mc_rd, mc_data,
    output mc_ready, stall_wb, rf_we, rf_rd, rf_data, mc_pending, waw_err
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Small FIFO holding multi-cycle results until they win the register-file write port.
// Every slot is exposed with a valid bit so the parent can decode pending registers.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_req_t               push_data,
  input  logic                  pop,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output wb_req_t [DEPTH-1:0]   entries,
  output logic    [DEPTH-1:0]   entry_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  wb_req_t          mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which slots are meaningful, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      offset         = PTR_W'(i) - rd_ptr_q;
      entries[i]     = mem_q[i];
      entry_valid[i] = ({1'b0, offset} < count_q);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between WB-stage writeback and
// buffered multi-cycle results, forcing a stall slot once a result waits MAX_WAIT cycles.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int MAX_WAIT  = 4
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_t            state_q, state_d;
  logic [WAIT_W-1:0]     wait_q,  wait_d;
  logic                  rf_we_q,   rf_we_d;
  logic [ADDR_W-1:0]     rf_rd_q,   rf_rd_d;
  logic [DATA_W-1:0]     rf_data_q, rf_data_d;
  logic                  waw_q,     waw_d;

  logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_req_t                  fifo_head;
  wb_req_t [BUF_DEPTH-1:0]  fifo_entries;
  logic    [BUF_DEPTH-1:0]  fifo_valid;
  logic    [NUM_REGS-1:0]   pending;
  logic                     grant, waw_hit;
  wb_req_t                  grant_req;

  assign fifo_push = bus.mc_valid && !fifo_full;

  wb_result_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .push_data   ('{rd: bus.mc_rd, data: bus.mc_data}),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entries     (fifo_entries),
    .entry_valid (fifo_valid)
  );

  // Pending map is decoded from the stored entries, so it trails push/pop by a cycle.
  always_comb begin
    pending = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (fifo_valid[i]) pending[fifo_entries[i].rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // The wait counter only advances while a buffered head is being refused.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      NORMAL: begin
        if (bus.wb_we && !fifo_empty) wait_d = wait_q + WAIT_W'(1);
        else                          wait_d = '0;
        if (wait_d == WAIT_W'(MAX_WAIT)) state_d = FORCE;
      end
      FORCE: begin
        wait_d  = '0;
        state_d = NORMAL;
      end
      default: begin
        wait_d  = '0;
        state_d = NORMAL;
      end
    endcase
  end

  always_comb begin
    grant     = 1'b0;
    grant_req = '0;
    fifo_pop  = 1'b0;
    waw_hit   = 1'b0;
    if (state_q == FORCE) begin
      if (!fifo_empty) begin
        grant     = 1'b1;
        grant_req = fifo_head;
        fifo_pop  = 1'b1;
      end
    end else if (bus.wb_we) begin
      grant     = 1'b1;
      grant_req = '{rd: bus.wb_rd, data: bus.wb_data};
      waw_hit   = pending[bus.wb_rd] && (bus.wb_rd != '0);
    end else if (!fifo_empty) begin
      grant     = 1'b1;
      grant_req = fifo_head;
      fifo_pop  = 1'b1;
    end

    // R0 writes still consume the slot but never assert the write enable.
    rf_we_d   = grant && (grant_req.rd != '0);
    rf_rd_d   = grant ? grant_req.rd   : rf_rd_q;
    rf_data_d = grant ? grant_req.data : rf_data_q;
    waw_d     = waw_q || waw_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      waw_q     <= 1'b0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      waw_q     <= waw_d;
    end
  end

  assign bus.mc_ready   = !fifo_full;
  assign bus.stall_wb   = (state_q == FORCE);
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_data    = rf_data_q;
  assign bus.mc_pending = pending;
  assign bus.waw_err    = waw_q;

endmodule
